// File: rtl/divider.sv
// Iterative 32-bit restoring divider: one quotient bit per clock, signed or unsigned,
// with a level request / completion pulse handshake and results held until the next operation.
module divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_begin,
    input  logic        div_signed,
    input  logic [31:0] div_op1,
    input  logic [31:0] div_op2,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_end,
    output logic        div_busy,
    output logic [1:0]  state_dbg
);

    // Handshake: div_begin is a level held by the issuer for the whole operation.
    // Dropping it during CALC aborts. div_end pulses for one cycle in DONE.
    // While div_begin stays high after completion the unit parks in HOLD.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] rem, dvd, divisor, op1_raw;
    logic        q_sign, r_sign, div_zero;
    logic [4:0]  cnt;

    logic [32:0] partial;
    logic [33:0] trial;
    logic        qbit;
    logic [31:0] rem_next, q_mag, q_fix, r_fix;
    logic        unused_bits;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (div_begin) state_next = CALC;
            CALC: begin
                if (!div_begin)       state_next = IDLE;
                else if (cnt == 5'd31) state_next = DONE;
            end
            DONE: state_next = div_begin ? HOLD : IDLE;
            HOLD: if (!div_begin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The shifted partial remainder can reach 33 bits, so the trial subtract is widened
    // and its top bit tells whether the divisor fits.
    always_comb begin
        partial     = {rem, dvd[31]};
        trial       = {1'b0, partial} - {2'b00, divisor};
        qbit        = ~trial[33];
        rem_next    = qbit ? trial[31:0] : partial[31:0];
        q_mag       = {dvd[30:0], qbit};
        q_fix       = q_sign ? (32'd0 - q_mag) : q_mag;
        r_fix       = r_sign ? (32'd0 - rem_next) : rem_next;
        unused_bits = trial[32];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem       <= '0;
            dvd       <= '0;
            divisor   <= '0;
            op1_raw   <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (state == IDLE && div_begin) begin
            rem      <= '0;
            dvd      <= (div_signed && div_op1[31]) ? (32'd0 - div_op1) : div_op1;
            divisor  <= (div_signed && div_op2[31]) ? (32'd0 - div_op2) : div_op2;
            op1_raw  <= div_op1;
            q_sign   <= div_signed & (div_op1[31] ^ div_op2[31]);
            r_sign   <= div_signed & div_op1[31];
            div_zero <= (div_op2 == 32'd0);
            cnt      <= '0;
        end else if (state == CALC && div_begin) begin
            rem <= rem_next;
            dvd <= q_mag;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                quotient  <= div_zero ? 32'hFFFF_FFFF : q_fix;
                remainder <= div_zero ? op1_raw : r_fix;
            end
        end
    end

    assign div_end   = (state == DONE);
    assign div_busy  = (state == CALC);
    assign state_dbg = state;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: hand-computed quotient/remainder vectors, latency,
// handshake (HOLD, abort) and asynchronous reset behaviour.
module tb_divider;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_begin;
    logic        div_signed;
    logic [31:0] div_op1, div_op2;
    logic [31:0] quotient, remainder;
    logic        div_end, div_busy;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_HOLD = 32'd3;

    divider dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_end    (div_end),
        .div_busy   (div_busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an operation (E0), scramble the operand inputs, and wait for div_end.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output int lat);
        div_op1    = a;
        div_op2    = b;
        div_signed = sgn;
        div_begin  = 1'b1;
        tick();
        div_op1    = $urandom;
        div_op2    = $urandom;
        div_signed = ~sgn;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (div_end) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r);
        int lat;
        int extra_ends;
        start_and_wait(a, b, sgn, lat);
        check({tag, "_latency"}, lat, 32'd32);
        check({tag, "_quot"}, quotient, exp_q);
        check({tag, "_rem"}, remainder, exp_r);
        check({tag, "_busy_done"}, {31'd0, div_busy}, 32'd0);
        extra_ends = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (div_end) extra_ends++;
        end
        check({tag, "_hold_state"}, {30'd0, state_dbg}, ST_HOLD);
        check({tag, "_no_second_end"}, extra_ends, 32'd0);
        div_begin = 1'b0;
        tick();
        check({tag, "_idle"}, {30'd0, state_dbg}, ST_IDLE);
        tick();
    endtask

    initial begin
        int lat;
        int ends;
        resetn     = 1'b0;
        div_begin  = 1'b0;
        div_signed = 1'b0;
        div_op1    = '0;
        div_op2    = '0;
        #12;
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_end", {31'd0, div_end}, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, ST_IDLE);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // busy right after E0
        div_op1 = 32'd564; div_op2 = 32'd7; div_signed = 1'b0; div_begin = 1'b1;
        tick();
        check("busy_after_e0", {31'd0, div_busy}, 32'd1);
        div_begin = 1'b0;
        tick();
        tick();

        run_op("u564_7", 32'd564, 32'd7, 1'b0, 32'd80, 32'd4);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
        run_op("s_div0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        run_op("u_div0", 32'h8765_4321, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h8765_4321);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);

        // Abort: drop div_begin before E10
        div_op1 = 32'd1000; div_op2 = 32'd3; div_signed = 1'b0; div_begin = 1'b1;
        tick();
        for (int i = 1; i <= 9; i++) tick();
        div_begin = 1'b0;
        tick();
        check("abort_idle", {30'd0, state_dbg}, ST_IDLE);
        ends = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_end) ends++;
            tick();
        end
        check("abort_no_end", ends, 32'd0);
        check("abort_quot_held", quotient, 32'hFFFF_FFFD);
        check("abort_rem_held", remainder, 32'd1);

        // Reset in the middle of CALC (after E20)
        div_op1 = 32'd55; div_op2 = 32'd5; div_signed = 1'b0; div_begin = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) tick();
        check("pre_reset_busy", {31'd0, div_busy}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_quot", quotient, 32'd0);
        check("midrst_rem", remainder, 32'd0);
        check("midrst_end", {31'd0, div_end}, 32'd0);
        check("midrst_busy", {31'd0, div_busy}, 32'd0);
        check("midrst_state", {30'd0, state_dbg}, ST_IDLE);
        div_begin = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();

        run_op("u100_10", 32'd100, 32'd10, 1'b0, 32'd10, 32'd0);
        start_and_wait(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
        check("s_m100_7_lat", lat, 32'd32);
        check("s_m100_7_quot", quotient, 32'hFFFF_FFF2);
        check("s_m100_7_rem", remainder, 32'hFFFF_FFFE);
        div_begin = 1'b0;
        tick();
        check("s_m100_7_idle", {30'd0, state_dbg}, ST_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
